// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encodings, bubble encoding, PC step.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: hazard controls, IMEM REQ/ACK handshake and IF/ID outputs.
interface if_fetch_unit_if;

  logic        PC_Write;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCP4;
  logic        IF_Valid;
  logic        IF_Fault;

  modport master (
    input  PC_Write, Redirect, Redirect_PC, IMEM_ACK, IMEM_RDATA,
    output IMEM_REQ, IMEM_ADDR, IF_INSTR, IF_PC, IF_PCP4, IF_Valid, IF_Fault
  );

  modport slave (
    output PC_Write, Redirect, Redirect_PC, IMEM_ACK, IMEM_RDATA,
    input  IMEM_REQ, IMEM_ADDR, IF_INSTR, IF_PC, IF_PCP4, IF_Valid, IF_Fault
  );

endinterface

// File: rtl/if_fetch_unit_wait_timer.sv
// Counts consecutive unacknowledged request cycles; raises a sticky fault at the limit.
module fetch_wait_timer #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  input  logic ack_i,
  output logic fault_o
);

  logic [7:0] count_q, count_d;
  logic       fault_q, fault_d;

  always_comb begin
    count_d = count_q;
    fault_d = fault_q;
    if (!req_i || ack_i) begin
      count_d = 8'd0;
    end else begin
      // Saturate so a very long wait cannot wrap back below the limit.
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
      if (count_d >= TIMEOUT_CYCLES) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign fault_o = fault_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the IMEM REQ/ACK handshake, feeds IF/ID.
// Optional fetch-timeout fault enabled by defining IF_FETCH_TIMEOUT_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR      = NOP,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic              clock,
  input  logic              reset,
  if_fetch_unit_if.master   fetch_io
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  stale_q, stale_d;
  logic         ack_fetch;
  logic         valid;
  logic         req;

  assign ack_fetch = (state_q == FETCH) && fetch_io.IMEM_ACK;
  assign valid     = !reset && !fetch_io.Redirect && (ack_fetch || (state_q == HOLD));
  assign req       = !reset && (state_q != HOLD);

  assign fetch_io.IMEM_REQ  = req;
  assign fetch_io.IMEM_ADDR = (state_q == DISCARD) ? stale_q : pc_q;
  assign fetch_io.IF_Valid  = valid;
  assign fetch_io.IF_INSTR  = !valid ? NOP_INSTR :
                              (state_q == HOLD) ? buf_q : fetch_io.IMEM_RDATA;
  assign fetch_io.IF_PC     = reset ? RESET_PC : pc_q;
  assign fetch_io.IF_PCP4   = reset ? pc_plus4(RESET_PC) : pc_plus4(pc_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    stale_d = stale_q;
    if (fetch_io.Redirect) begin
      pc_d = {fetch_io.Redirect_PC[31:2], 2'b00};
      unique case (state_q)
        FETCH: begin
          // The un-acked request is still in flight; remember its address so
          // IMEM_ADDR stays stable until it completes.
          if (!fetch_io.IMEM_ACK) begin
            stale_d = pc_q;
            state_d = DISCARD;
          end
        end
        HOLD:    state_d = FETCH;
        DISCARD: state_d = DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (fetch_io.IMEM_ACK) begin
            if (fetch_io.PC_Write) begin
              pc_d = pc_plus4(pc_q);
            end else begin
              buf_d   = fetch_io.IMEM_RDATA;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (fetch_io.PC_Write) begin
            pc_d    = pc_plus4(pc_q);
            state_d = FETCH;
          end
        end
        DISCARD: begin
          if (fetch_io.IMEM_ACK) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
      stale_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      stale_q <= stale_d;
    end
  end

`ifdef IF_FETCH_TIMEOUT_EN
  logic fault;

  fetch_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .req_i   (req),
    .ack_i   (fetch_io.IMEM_ACK),
    .fault_o (fault)
  );

  assign fetch_io.IF_Fault = fault;
`else
  assign fetch_io.IF_Fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queue-based scoreboard of accepted instructions.
module tb_if_fetch_unit;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic [7:0] TB_TMO = 8'd4;
  localparam bit         TB_FLT = 1'b1;
`else
  localparam logic [7:0] TB_TMO = 8'd255;
  localparam bit         TB_FLT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic        use_force = 1'b0;
  logic [31:0] force_data = 32'd0;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .NOP_INSTR      (32'h0000_0000),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .fetch_io (bus.master)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {8'h24, a[23:0]};
  endfunction

  always_comb begin
    if (use_force) bus.IMEM_RDATA = force_data;
    else if (bus.IMEM_ACK) bus.IMEM_RDATA = mem(bus.IMEM_ADDR);
    else bus.IMEM_RDATA = 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set(input logic pw, input logic rd, input logic [31:0] rpc, input logic ak);
    bus.PC_Write    = pw;
    bus.Redirect    = rd;
    bus.Redirect_PC = rpc;
    bus.IMEM_ACK    = ak;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every instruction accepted into IF/ID must match the next expected one.
  always @(negedge clock) begin
    logic [63:0] e;
    if (!reset && bus.IF_Valid === 1'b1 && bus.PC_Write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr_pc", bus.IF_PC, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.IF_PC, e[63:32]);
        chk("sb_instr", bus.IF_INSTR, e[31:0]);
      end
    end
  end

  initial begin
    set(1'b1, 1'b0, 32'd0, 1'b0);
    nxt();
    neg();
    chk("rst_req", {31'd0, bus.IMEM_REQ}, 32'd0);
    chk("rst_instr", bus.IF_INSTR, 32'd0);
    chk("rst_valid", {31'd0, bus.IF_Valid}, 32'd0);
    chk("rst_pc", bus.IF_PC, 32'd0);
    chk("rst_pcp4", bus.IF_PCP4, 32'd4);
    chk("rst_fault", {31'd0, bus.IF_Fault}, 32'd0);
    nxt();
    reset = 1'b0;

    // Zero-wait memory: one instruction per cycle.
    for (int k = 0; k < 4; k++) begin
      set(1'b1, 1'b0, 32'd0, 1'b1);
      push(32'(4 * k), mem(32'(4 * k)));
      neg();
      chk("zw_addr", bus.IMEM_ADDR, 32'(4 * k));
      chk("zw_valid", {31'd0, bus.IF_Valid}, 32'd1);
      chk("zw_pcp4", bus.IF_PCP4, 32'(4 * k + 4));
      nxt();
    end

    // Slow memory: three bubble cycles at 0x10.
    for (int k = 0; k < 3; k++) begin
      set(1'b1, 1'b0, 32'd0, 1'b0);
      neg();
      chk("slow_addr", bus.IMEM_ADDR, 32'h10);
      chk("slow_valid", {31'd0, bus.IF_Valid}, 32'd0);
      chk("slow_instr", bus.IF_INSTR, 32'd0);
      nxt();
    end
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h10, mem(32'h10));
    neg();
    chk("slow_ack_valid", {31'd0, bus.IF_Valid}, 32'd1);
    nxt();

    // Stall capture at 0x14 into HOLD.
    use_force = 1'b1;
    force_data = 32'h8C22_0004;
    set(1'b0, 1'b0, 32'd0, 1'b1);
    neg();
    chk("cap_instr", bus.IF_INSTR, 32'h8C22_0004);
    nxt();
    use_force = 1'b0;
    set(1'b0, 1'b0, 32'd0, 1'b0);
    neg();
    chk("hold_req", {31'd0, bus.IMEM_REQ}, 32'd0);
    chk("hold_instr", bus.IF_INSTR, 32'h8C22_0004);
    chk("hold_valid", {31'd0, bus.IF_Valid}, 32'd1);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b0);
    push(32'h14, 32'h8C22_0004);
    neg();
    chk("hold_rel_req", {31'd0, bus.IMEM_REQ}, 32'd0);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b0);
    neg();
    chk("after_hold_addr", bus.IMEM_ADDR, 32'h18);
    chk("after_hold_req", {31'd0, bus.IMEM_REQ}, 32'd1);
    nxt();
    set(1'b1, 1'b1, 32'h40, 1'b1);
    neg();
    chk("redir_ack_valid", {31'd0, bus.IF_Valid}, 32'd0);
    chk("redir_ack_instr", bus.IF_INSTR, 32'd0);
    nxt();

    // Redirect with a request outstanding at 0x40.
    set(1'b1, 1'b1, 32'h200, 1'b0);
    neg();
    chk("disc_in_addr", bus.IMEM_ADDR, 32'h40);
    chk("disc_in_valid", {31'd0, bus.IF_Valid}, 32'd0);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b0);
    neg();
    chk("disc_addr", bus.IMEM_ADDR, 32'h40);
    chk("disc_req", {31'd0, bus.IMEM_REQ}, 32'd1);
    chk("disc_pc", bus.IF_PC, 32'h200);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    neg();
    chk("disc_ack_valid", {31'd0, bus.IF_Valid}, 32'd0);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h200, mem(32'h200));
    neg();
    chk("new_path_addr", bus.IMEM_ADDR, 32'h200);
    nxt();

    // Redirect wins over stall; unaligned target.
    set(1'b0, 1'b1, 32'h103, 1'b1);
    neg();
    chk("redir_stall_valid", {31'd0, bus.IF_Valid}, 32'd0);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h100, mem(32'h100));
    neg();
    chk("align_pc", bus.IF_PC, 32'h100);
    chk("align_addr", bus.IMEM_ADDR, 32'h100);
    nxt();
    set(1'b0, 1'b0, 32'd0, 1'b1);
    neg();
    nxt();
    set(1'b0, 1'b1, 32'h300, 1'b0);
    neg();
    chk("redir_hold_valid", {31'd0, bus.IF_Valid}, 32'd0);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h300, mem(32'h300));
    neg();
    chk("redir_hold_addr", bus.IMEM_ADDR, 32'h300);
    nxt();

    // Second redirect while discarding keeps the stale address.
    set(1'b1, 1'b1, 32'h400, 1'b0);
    neg();
    nxt();
    set(1'b1, 1'b1, 32'h502, 1'b0);
    neg();
    chk("disc2_addr", bus.IMEM_ADDR, 32'h304);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    neg();
    chk("disc2_valid", {31'd0, bus.IF_Valid}, 32'd0);
    chk("disc2_pc", bus.IF_PC, 32'h500);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h500, mem(32'h500));
    neg();
    chk("disc2_new_addr", bus.IMEM_ADDR, 32'h500);
    nxt();

    // PC wrap at the top of the address space.
    set(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    neg();
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'hFFFF_FFFC, mem(32'hFFFF_FFFC));
    neg();
    chk("wrap_pcp4", bus.IF_PCP4, 32'd0);
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h0, mem(32'h0));
    neg();
    chk("wrap_addr", bus.IMEM_ADDR, 32'd0);
    nxt();

    // Withheld ACK: fault only when the timeout feature is built in.
    for (int k = 1; k <= 6; k++) begin
      set(1'b1, 1'b0, 32'd0, 1'b0);
      neg();
      chk("tmo_fault", {31'd0, bus.IF_Fault}, {31'd0, (TB_FLT && k >= 5)});
      chk("tmo_addr", bus.IMEM_ADDR, 32'h4);
      nxt();
    end
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h4, mem(32'h4));
    neg();
    chk("tmo_sticky_ack", {31'd0, bus.IF_Fault}, {31'd0, TB_FLT});
    nxt();
    set(1'b1, 1'b0, 32'd0, 1'b1);
    push(32'h8, mem(32'h8));
    neg();
    chk("tmo_sticky", {31'd0, bus.IF_Fault}, {31'd0, TB_FLT});
    nxt();

    // Reset mid-request clears the fault and restarts at RESET_PC.
    reset = 1'b1;
    set(1'b1, 1'b0, 32'd0, 1'b0);
    neg();
    chk("rst2_req", {31'd0, bus.IMEM_REQ}, 32'd0);
    nxt();
    reset = 1'b0;
    neg();
    chk("rst2_fault", {31'd0, bus.IF_Fault}, 32'd0);
    chk("rst2_pc", bus.IF_PC, 32'd0);
    chk("rst2_addr", bus.IMEM_ADDR, 32'd0);
    nxt();

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
